// File: rtl/xcel_mem_responder_pkg.sv
// Shared FSM encodings and word-addressing constants for the memory responder.
package xcel_mem_pkg;
  localparam int WORD_BYTES       = 4;
  localparam int BYTE_OFFSET_BITS = 2;

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;
  typedef enum logic       {W_IDLE, W_DATA}          wr_state_e;
endpackage

// File: rtl/xcel_mem_responder_if.sv
// Burst read/write request and data channels between an accelerator initiator and a memory.
interface xcel_mem_responder_if #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
);
  logic                  read_request_valid;
  logic                  read_request_ready;
  logic [AXI_AWIDTH-1:0] read_request_addr;
  logic [31:0]           read_len;
  logic [2:0]            read_size;
  logic [AXI_DWIDTH-1:0] read_data;
  logic                  read_data_valid;
  logic                  read_data_ready;
  logic                  write_request_valid;
  logic                  write_request_ready;
  logic [AXI_AWIDTH-1:0] write_request_addr;
  logic [31:0]           write_len;
  logic [2:0]            write_size;
  logic [AXI_DWIDTH-1:0] write_data;
  logic                  write_data_valid;
  logic                  write_data_ready;

  modport master (
    output read_request_valid, read_request_addr, read_len, read_size, read_data_ready,
    input  read_request_ready, read_data, read_data_valid,
    output write_request_valid, write_request_addr, write_len, write_size,
    output write_data, write_data_valid,
    input  write_request_ready, write_data_ready
  );

  modport slave (
    input  read_request_valid, read_request_addr, read_len, read_size, read_data_ready,
    output read_request_ready, read_data, read_data_valid,
    input  write_request_valid, write_request_addr, write_len, write_size,
    input  write_data, write_data_valid,
    output write_request_ready, write_data_ready
  );
endinterface

// File: rtl/xcel_mem_responder_sram_1r1w.sv
// Simple dual-port SRAM: one synchronous read port, one write port, read-first on collision.
module xcel_sram_1r1w #(
  parameter int MEM_AWIDTH = 14,
  parameter int DWIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic [MEM_AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0]     rdata,
  input  logic                  we,
  input  logic [MEM_AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0]     wdata
);
  logic [DWIDTH-1:0] mem [0:(1<<MEM_AWIDTH)-1];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Output register only is reset; it holds its value until the next read.
  always_ff @(posedge clk)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/xcel_mem_responder.sv
// Memory-side responder serving burst reads and writes from on-chip SRAM; channels run independently.
module xcel_mem_responder
  import xcel_mem_pkg::*;
#(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter int MEM_AWIDTH = 14
) (
  input logic clk,
  input logic rst,
  xcel_mem_responder_if.slave bus
);
  typedef logic [MEM_AWIDTH-1:0] idx_t;

  rd_state_e             r_state, r_next;
  wr_state_e             w_state, w_next;
  idx_t                  r_idx, w_idx;
  logic [31:0]           r_rem, w_rem;
  logic                  r_req_hs, r_beat_hs, w_req_hs, w_beat_hs, sram_re;
  logic [AXI_DWIDTH-1:0] sram_rdata;
  logic                  unused_bits;

  function automatic idx_t word_idx(input logic [AXI_AWIDTH-1:0] a);
    return a[MEM_AWIDTH+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS];
  endfunction

  assign unused_bits = ^{bus.read_size, bus.write_size, bus.read_request_addr, bus.write_request_addr};

  assign r_req_hs  = bus.read_request_valid  & bus.read_request_ready;
  assign r_beat_hs = bus.read_data_valid     & bus.read_data_ready;
  assign w_req_hs  = bus.write_request_valid & bus.write_request_ready;
  assign w_beat_hs = bus.write_data_valid    & bus.write_data_ready;

  // Handshake outputs are forced low while rst is high so nothing transfers mid-reset.
  always_comb begin
    r_next                 = r_state;
    bus.read_request_ready = 1'b0;
    bus.read_data_valid    = 1'b0;
    sram_re                = 1'b0;
    if (!rst) begin
      unique case (r_state)
        R_IDLE: begin
          bus.read_request_ready = 1'b1;
          if (bus.read_request_valid) r_next = R_FETCH;
        end
        R_FETCH: begin
          sram_re = 1'b1;
          r_next  = R_DATA;
        end
        R_DATA: begin
          bus.read_data_valid = 1'b1;
          if (bus.read_data_ready) r_next = (r_rem == '0) ? R_IDLE : R_FETCH;
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= r_next;
      if (r_req_hs) begin
        r_idx <= word_idx(bus.read_request_addr);
        r_rem <= bus.read_len;
      end else if (r_beat_hs && r_rem != '0) begin
        r_idx <= r_idx + 1'b1;
        r_rem <= r_rem - 1'b1;
      end
    end
  end

  always_comb begin
    w_next                  = w_state;
    bus.write_request_ready = 1'b0;
    bus.write_data_ready    = 1'b0;
    if (!rst) begin
      unique case (w_state)
        W_IDLE: begin
          bus.write_request_ready = 1'b1;
          if (bus.write_request_valid) w_next = W_DATA;
        end
        W_DATA: begin
          bus.write_data_ready = 1'b1;
          if (bus.write_data_valid && w_rem == '0) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_rem   <= '0;
    end else begin
      w_state <= w_next;
      if (w_req_hs) begin
        w_idx <= word_idx(bus.write_request_addr);
        w_rem <= bus.write_len;
      end else if (w_beat_hs && w_rem != '0) begin
        w_idx <= w_idx + 1'b1;
        w_rem <= w_rem - 1'b1;
      end
    end
  end

  xcel_sram_1r1w #(.MEM_AWIDTH(MEM_AWIDTH), .DWIDTH(AXI_DWIDTH)) u_sram (
    .clk   (clk),
    .rst   (rst),
    .re    (sram_re),
    .raddr (r_idx),
    .rdata (sram_rdata),
    .we    (w_beat_hs),
    .waddr (w_idx),
    .wdata (bus.write_data)
  );

  assign bus.read_data = sram_rdata;
endmodule

// File: tb/tb_xcel_mem_responder.sv
// Directed and randomized bursts against a word-array model of the responder's memory.
module tb_xcel_mem_responder;
  localparam int MEM_AWIDTH = 14;
  localparam int WORDS      = 1 << MEM_AWIDTH;
  localparam int BOUND      = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xcel_mem_responder_if #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) bus ();

  xcel_mem_responder #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .MEM_AWIDTH(MEM_AWIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [WORDS];
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  int          rd_first, rd_cyc, rd_req_wait;

  function automatic int widx(input logic [31:0] addr, input int i);
    return int'(((addr >> 2) + 32'(i)) % WORDS);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_rq(input logic [31:0] addr, input int n);
    rq.delete();
    for (int i = 0; i < n; i++) rq.push_back(model[widx(addr, i)]);
  endtask

  task automatic wr_req(input logic [31:0] addr, input int n);
    logic got = 1'b0;
    bus.write_request_valid = 1'b1;
    bus.write_request_addr  = addr;
    bus.write_len           = 32'(n - 1);
    bus.write_size          = 3'd2;
    for (int c = 0; c < BOUND && !got; c++) begin
      @(negedge clk);
      if (bus.write_request_ready) got = 1'b1;
      @(posedge clk);
    end
    #1 bus.write_request_valid = 1'b0;
    chk("wr_req_hs", {31'd0, got}, 32'd1);
  endtask

  task automatic wr_beat(input logic [31:0] data, input int word);
    logic got = 1'b0;
    bus.write_data_valid = 1'b1;
    bus.write_data       = data;
    for (int c = 0; c < BOUND && !got; c++) begin
      @(negedge clk);
      if (bus.write_data_ready) got = 1'b1;
      @(posedge clk);
    end
    if (got) model[word] = data;
    else chk("wr_beat_timeout", {31'd0, got}, 32'd1);
    #1 bus.write_data_valid = 1'b0;
  endtask

  // gapmode: 0 back-to-back, 1 one idle cycle before beat 1, 2 random idle cycles
  task automatic do_write(input logic [31:0] addr, input int n, input int gapmode);
    wr_req(addr, n);
    for (int i = 0; i < n; i++) begin
      if ((gapmode == 1 && i == 1) || (gapmode == 2 && $urandom_range(0, 1) == 1)) begin
        bus.write_data_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      wr_beat(wq[i], widx(addr, i));
    end
  endtask

  // mode: 0 ready always, 1 ready every third cycle, 2 random ready
  task automatic do_read(input logic [31:0] addr, input int n, input int mode);
    logic        got = 1'b0, held_v = 1'b0, rdy;
    logic [31:0] held_d = '0;
    int          beats = 0, cyc = 0;
    bus.read_request_valid = 1'b1;
    bus.read_request_addr  = addr;
    bus.read_len           = 32'(n - 1);
    bus.read_size          = 3'd2;
    rd_req_wait = 0;
    for (int c = 0; c < BOUND && !got; c++) begin
      @(negedge clk);
      rd_req_wait = c + 1;
      if (bus.read_request_ready) got = 1'b1;
      @(posedge clk);
    end
    #1 bus.read_request_valid = 1'b0;
    chk("rd_req_hs", {31'd0, got}, 32'd1);
    rd_first = -1;
    while (beats < n && cyc < BOUND * n) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      bus.read_data_ready = rdy;
      @(negedge clk);
      cyc++;
      if (held_v) begin
        chk("rd_hold_valid", {31'd0, bus.read_data_valid}, 32'd1);
        chk("rd_hold_data", bus.read_data, held_d);
      end
      if (bus.read_data_valid) begin
        if (rd_first < 0) rd_first = cyc;
        if (rdy) begin
          chk($sformatf("rd_beat%0d", beats), bus.read_data, rq[beats]);
          beats++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_d = bus.read_data;
        end
      end else held_v = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.read_data_ready = 1'b0;
    rd_cyc = cyc;
    chk("rd_beat_count", 32'(beats), 32'(n));
    @(negedge clk);
    chk("rd_idle_req_ready", {31'd0, bus.read_request_ready}, 32'd1);
    chk("rd_idle_no_valid", {31'd0, bus.read_data_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          n;
    bus.read_request_valid  = 1'b0; bus.read_request_addr  = '0; bus.read_len  = '0;
    bus.read_size           = 3'd2; bus.read_data_ready    = 1'b0;
    bus.write_request_valid = 1'b0; bus.write_request_addr = '0; bus.write_len = '0;
    bus.write_size          = 3'd2; bus.write_data = '0;   bus.write_data_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_req_ready", {31'd0, bus.read_request_ready}, 32'd0);
    chk("rst_wr_req_ready", {31'd0, bus.write_request_ready}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.read_data_valid}, 32'd0);
    chk("rst_wr_data_ready", {31'd0, bus.write_data_ready}, 32'd0);
    chk("rst_rd_data", bus.read_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rd_ready", {31'd0, bus.read_request_ready}, 32'd1);
    chk("post_rst_wr_ready", {31'd0, bus.write_request_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Fill the whole memory so the model is fully known
    wq.delete();
    for (int i = 0; i < WORDS; i++) wq.push_back($urandom);
    do_write(32'h0, WORDS, 0);

    // Single read, plus ignored upper and low address bits
    wq = '{32'hDEADBEEF};
    do_write(32'h14, 1, 0);
    rq = '{32'hDEADBEEF};
    do_read(32'h14, 1, 0);
    chk("rd_first_latency", 32'(rd_first), 32'd2);
    do_read(32'h0001_0017, 1, 2);

    // Burst with backpressure
    wq = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_write(32'h20, 4, 0);
    rq = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_read(32'h20, 4, 1);
    do_read(32'h20, 4, 0);
    chk("rd_throughput_cycles", 32'(rd_cyc), 32'd8);

    // Write with a gap, then readback
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_write(32'h40, 4, 1);
    rq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_read(32'h40, 4, 2);

    // Write data offered while idle must be refused
    bus.write_data_valid = 1'b1;
    bus.write_data       = 32'hBAD0BAD0;
    @(negedge clk);
    chk("idle_wr_data_ready", {31'd0, bus.write_data_ready}, 32'd0);
    @(posedge clk);
    #1 bus.write_data_valid = 1'b0;
    load_rq(32'h40, 4);
    do_read(32'h40, 4, 0);

    // Concurrent channels: word 0 is fetched on the same edge it is written
    wq = '{32'd0, 32'd0, 32'd0, 32'd0};
    do_write(32'h0, 4, 0);
    wq = '{32'd100, 32'd101, 32'd102, 32'd103};
    rq = '{32'd0, 32'd101, 32'd102, 32'd103};
    fork
      do_write(32'h0, 4, 0);
      do_read(32'h0, 4, 0);
    join
    rq = '{32'd100, 32'd101, 32'd102, 32'd103};
    do_read(32'h0, 4, 0);

    // Index wrap at the top of memory
    wq = '{32'h1111_AAAA, 32'h2222_BBBB};
    do_write(32'hFFFC, 2, 0);
    rq = '{32'h1111_AAAA, 32'h2222_BBBB};
    do_read(32'hFFFC, 2, 0);
    rq = '{32'h2222_BBBB};
    do_read(32'h0, 1, 0);

    // Reset mid-burst after 3 of 8 beats
    wr_req(32'h200, 8);
    for (int i = 0; i < 3; i++) wr_beat(32'hC0DE_0000 + 32'(i), widx(32'h200, i));
    rst = 1'b1;
    bus.write_data_valid = 1'b1;
    bus.write_data       = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_wr_data_ready", {31'd0, bus.write_data_ready}, 32'd0);
      chk("midrst_wr_req_ready", {31'd0, bus.write_request_ready}, 32'd0);
      chk("midrst_rd_req_ready", {31'd0, bus.read_request_ready}, 32'd0);
      @(posedge clk);
    end
    #1 rst = 1'b0;
    bus.write_data_valid = 1'b0;
    load_rq(32'h200, 5);
    do_read(32'h200, 5, 0);
    chk("post_midrst_req_wait", 32'(rd_req_wait), 32'd1);

    // Randomized bursts against the model
    for (int t = 0; t < 8; t++) begin
      a = $urandom;
      n = $urandom_range(1, 8);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      do_write(a, n, 2);
      load_rq(a, n);
      do_read(a, n, 2);
      a = $urandom;
      load_rq(a, 3);
      do_read(a, 3, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
